// File: rtl/vstore_stream_arbiter_if.sv
// Store-stream bundle between the ALU slots, the arbiter and the store AXI wrapper.
interface vstore_stream_arbiter_if #(
  parameter int unsigned SLOT_COUNT = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned SLOT_W = $clog2(SLOT_COUNT) + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic                                  flush;
  logic [SLOT_COUNT-1:0]                 slot_valid;
  logic [SLOT_COUNT-1:0]                 slot_start;
  logic [SLOT_COUNT-1:0]                 slot_end;
  logic [SLOT_COUNT-1:0][DATA_WIDTH-1:0] slot_data;
  logic [SLOT_COUNT-1:0][BE_W-1:0]       slot_be;
  logic [SLOT_COUNT-1:0]                 slot_ready;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [DATA_WIDTH-1:0]                 out_data;
  logic [BE_W-1:0]                       out_be;
  logic                                  out_start;
  logic                                  out_end;
  logic [SLOT_W-1:0]                     out_slot;
  logic                                  burst_active;
  logic [CNT_W-1:0]                      fifo_count;
  logic                                  protocol_err;

  // Producer side: slots, flush control and the downstream consumer.
  modport master (
    output flush, slot_valid, slot_start, slot_end, slot_data, slot_be, out_ready,
    input  slot_ready, out_valid, out_data, out_be, out_start, out_end, out_slot,
           burst_active, fifo_count, protocol_err
  );

  // Arbiter side.
  modport slave (
    input  flush, slot_valid, slot_start, slot_end, slot_data, slot_be, out_ready,
    output slot_ready, out_valid, out_data, out_be, out_start, out_end, out_slot,
           burst_active, fifo_count, protocol_err
  );
endinterface

// File: rtl/vstore_stream_arbiter.sv
// N-slot vector-store stream arbiter: burst-locked grant, FWFT output FIFO,
// per-slot backpressure, fixed-priority or round-robin selection.
module vstore_stream_arbiter #(
  parameter int unsigned SLOT_COUNT = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  vstore_stream_arbiter_if.slave bus
);
  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned SLOT_W = $clog2(SLOT_COUNT) + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned IDX_W  = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic [SLOT_W-1:0]     slot;
    logic                  first;
    logic                  last;
    logic [BE_W-1:0]       be;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               err_q, err_d;
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  beat_t              mem_q [FIFO_DEPTH];
  beat_t              mem_d [FIFO_DEPTH];

  logic [SLOT_COUNT-1:0] cand_c;
  logic [SLOT_COUNT-1:0] ready_c;
  logic [IDX_W-1:0]      win_c;
  logic [IDX_W-1:0]      sel_c;
  logic                  found_c;
  int                    rr_idx_c;
  logic                  full_c;
  logic                  push_c;
  logic                  pop_c;
  beat_t                 beat_c;
  beat_t                 head_c;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] x);
    if (int'(x) >= int'(SLOT_COUNT) - 1) next_idx = '0;
    else                                 next_idx = x + IDX_W'(1);
  endfunction

  assign full_c = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop_c  = (cnt_q != '0) && bus.out_ready;
  assign head_c = mem_q[rd_q];

  // Pick the start-candidate winner for this cycle according to ARB_MODE.
  always_comb begin
    cand_c   = bus.slot_valid & bus.slot_start;
    win_c    = '0;
    found_c  = 1'b0;
    rr_idx_c = 0;
    if (ARB_MODE == 0) begin
      for (int i = 0; i < int'(SLOT_COUNT); i++) begin
        if (cand_c[i]) win_c = IDX_W'(i);
      end
    end else begin
      for (int k = 0; k < int'(SLOT_COUNT); k++) begin
        rr_idx_c = (int'(rr_q) + k) % int'(SLOT_COUNT);
        if (!found_c && cand_c[rr_idx_c]) begin
          win_c   = IDX_W'(rr_idx_c);
          found_c = 1'b1;
        end
      end
    end
  end

  // Beat presented by the currently selected slot.
  always_comb begin
    sel_c       = (state_q == IDLE) ? win_c : grant_q;
    beat_c.slot  = SLOT_W'(sel_c);
    beat_c.first = bus.slot_start[sel_c];
    beat_c.last  = bus.slot_end[sel_c];
    beat_c.be    = bus.slot_be[sel_c];
    beat_c.data  = bus.slot_data[sel_c];
  end

  // Grant FSM, per-slot ready, FIFO bookkeeping and flush override.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    err_d   = err_q;
    ready_c = '0;
    push_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|cand_c) begin
          if (!full_c) begin
            ready_c[win_c] = 1'b1;
            push_c         = 1'b1;
            if (bus.slot_end[win_c]) begin
              if (ARB_MODE == 1) rr_d = next_idx(win_c);
            end else begin
              state_d = LOCKED;
              grant_d = win_c;
            end
          end
        end else if (|bus.slot_valid) begin
          // Mid-burst beats with no open burst are swallowed and flagged.
          ready_c = bus.slot_valid;
          err_d   = 1'b1;
        end
      end
      LOCKED: begin
        if (!full_c) begin
          ready_c[grant_q] = 1'b1;
          if (bus.slot_valid[grant_q]) begin
            push_c = 1'b1;
            if (bus.slot_start[grant_q]) err_d = 1'b1;
            if (bus.slot_end[grant_q]) begin
              state_d = IDLE;
              if (ARB_MODE == 1) rr_d = next_idx(grant_q);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_d  = wr_q + PTR_W'(push_c);
    rd_d  = rd_q + PTR_W'(pop_c);
    mem_d = mem_q;
    if (push_c) mem_d[wr_q] = beat_c;
    unique case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (bus.flush) begin
      state_d = IDLE;
      grant_d = '0;
      rr_d    = '0;
      err_d   = 1'b0;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
    end
  end

  // Control registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO storage; contents are masked at the output whenever empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.slot_ready   = ready_c;
  assign bus.out_valid    = (cnt_q != '0);
  assign bus.out_data     = bus.out_valid ? head_c.data  : '0;
  assign bus.out_be       = bus.out_valid ? head_c.be    : '0;
  assign bus.out_start    = bus.out_valid & head_c.first;
  assign bus.out_end      = bus.out_valid & head_c.last;
  assign bus.out_slot     = bus.out_valid ? head_c.slot  : '0;
  assign bus.burst_active = (state_q == LOCKED);
  assign bus.fifo_count   = cnt_q;
  assign bus.protocol_err = err_q;
endmodule

// File: tb/tb_vstore_stream_arbiter.sv
// Directed bench: fixed-priority 2-slot instance (A) and round-robin 4-slot instance (B).
module tb_vstore_stream_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vstore_stream_arbiter_if #(.SLOT_COUNT(2), .DATA_WIDTH(32), .FIFO_DEPTH(4)) ifa ();
  vstore_stream_arbiter_if #(.SLOT_COUNT(4), .DATA_WIDTH(16), .FIFO_DEPTH(4)) ifb ();

  vstore_stream_arbiter #(.SLOT_COUNT(2), .DATA_WIDTH(32), .FIFO_DEPTH(4), .ARB_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  vstore_stream_arbiter #(.SLOT_COUNT(4), .DATA_WIDTH(16), .FIFO_DEPTH(4), .ARB_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        flush;
    logic [1:0]  v, s, e;
    logic [31:0] d0, d1;
    logic        ordy;
    logic [1:0]  x_rdy;
    logic        x_valid;
    logic [31:0] x_data;
    logic        x_slot, x_start, x_end;
    logic [2:0]  x_cnt;
    logic        x_burst, x_err;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic [1:0] v, input logic [1:0] s,
                              input logic [1:0] e, input logic [31:0] d0, input logic [31:0] d1,
                              input logic ordy, input logic [1:0] rdy, input logic val,
                              input logic [31:0] dat, input logic sl, input logic st,
                              input logic en, input logic [2:0] cnt, input logic bu,
                              input logic er);
    vec_t r;
    r.flush = fl; r.v = v; r.s = s; r.e = e; r.d0 = d0; r.d1 = d1; r.ordy = ordy;
    r.x_rdy = rdy; r.x_valid = val; r.x_data = dat; r.x_slot = sl; r.x_start = st;
    r.x_end = en; r.x_cnt = cnt; r.x_burst = bu; r.x_err = er;
    return r;
  endfunction

  vec_t        tbl [15];
  logic [31:0] rx_data [6];
  logic        rx_st [6];
  logic        rx_en [6];
  int          idx;
  int          nrx;
  logic        got_rdy;

  task automatic drive_a0(input int i, input int last);
    ifa.slot_valid   = 2'b01;
    ifa.slot_start   = {1'b0, (i == 0)};
    ifa.slot_end     = {1'b0, (i == last)};
    ifa.slot_data[0] = 32'h30 + 32'(i);
  endtask

  initial begin
    rst = 1'b1;
    ifa.flush = 1'b0; ifa.slot_valid = '0; ifa.slot_start = '0; ifa.slot_end = '0;
    ifa.slot_data[0] = '0; ifa.slot_data[1] = '0;
    ifa.slot_be[0] = 4'h3; ifa.slot_be[1] = 4'hC; ifa.out_ready = 1'b0;
    ifb.flush = 1'b0; ifb.slot_valid = '0; ifb.slot_start = '0; ifb.slot_end = '0;
    ifb.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ifb.slot_data[k] = 16'h100 + 16'(k);
      ifb.slot_be[k]   = 2'b11;
    end

    // Two 3-beat bursts, protocol drop, flush, single-beat latency, start-while-locked.
    tbl[0]  = mk(0, 2'b11, 2'b11, 2'b00, 32'h00, 32'h10, 1, 2'b10, 1, 32'h10, 1, 1, 0, 1, 1, 0);
    tbl[1]  = mk(0, 2'b11, 2'b01, 2'b00, 32'h00, 32'h11, 1, 2'b10, 1, 32'h11, 1, 0, 0, 1, 1, 0);
    tbl[2]  = mk(0, 2'b11, 2'b01, 2'b10, 32'h00, 32'h12, 1, 2'b10, 1, 32'h12, 1, 0, 1, 1, 0, 0);
    tbl[3]  = mk(0, 2'b01, 2'b01, 2'b00, 32'h00, 32'h00, 1, 2'b01, 1, 32'h00, 0, 1, 0, 1, 1, 0);
    tbl[4]  = mk(0, 2'b01, 2'b00, 2'b00, 32'h01, 32'h00, 1, 2'b01, 1, 32'h01, 0, 0, 0, 1, 1, 0);
    tbl[5]  = mk(0, 2'b01, 2'b00, 2'b01, 32'h02, 32'h00, 1, 2'b01, 1, 32'h02, 0, 0, 1, 1, 0, 0);
    tbl[6]  = mk(0, 2'b00, 2'b00, 2'b00, 32'h00, 32'h00, 1, 2'b00, 0, 32'h00, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 2'b10, 2'b00, 2'b00, 32'h00, 32'h77, 1, 2'b10, 0, 32'h00, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(0, 2'b00, 2'b00, 2'b00, 32'h00, 32'h00, 1, 2'b00, 0, 32'h00, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(1, 2'b00, 2'b00, 2'b00, 32'h00, 32'h00, 1, 2'b00, 0, 32'h00, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 2'b11, 2'b01, 2'b01, 32'h55, 32'h66, 1, 2'b01, 1, 32'h55, 0, 1, 1, 1, 0, 0);
    tbl[11] = mk(0, 2'b00, 2'b00, 2'b00, 32'h00, 32'h00, 1, 2'b00, 0, 32'h00, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 2'b10, 2'b10, 2'b00, 32'h00, 32'h20, 1, 2'b10, 1, 32'h20, 1, 1, 0, 1, 1, 0);
    tbl[13] = mk(0, 2'b10, 2'b10, 2'b10, 32'h00, 32'h21, 1, 2'b10, 1, 32'h21, 1, 1, 1, 1, 0, 1);
    tbl[14] = mk(1, 2'b00, 2'b00, 2'b00, 32'h00, 32'h00, 1, 2'b00, 0, 32'h00, 0, 0, 0, 0, 0, 0);

    // Reset state
    #12;
    chk("rst_a_valid", ifa.out_valid, 0);
    chk("rst_a_cnt", ifa.fifo_count, 0);
    chk("rst_a_rdy", ifa.slot_ready, 0);
    chk("rst_a_burst", ifa.burst_active, 0);
    chk("rst_a_err", ifa.protocol_err, 0);
    chk("rst_a_data", ifa.out_data, 0);
    chk("rst_a_slot", ifa.out_slot, 0);
    chk("rst_b_valid", ifb.out_valid, 0);
    chk("rst_b_cnt", ifb.fifo_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors on instance A
    for (int i = 0; i < 15; i++) begin
      ifa.flush = tbl[i].flush;
      ifa.slot_valid = tbl[i].v; ifa.slot_start = tbl[i].s; ifa.slot_end = tbl[i].e;
      ifa.slot_data[0] = tbl[i].d0; ifa.slot_data[1] = tbl[i].d1;
      ifa.out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_rdy", i), ifa.slot_ready, tbl[i].x_rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), ifa.out_valid, tbl[i].x_valid);
      chk($sformatf("v%0d_data", i), ifa.out_data, tbl[i].x_data);
      chk($sformatf("v%0d_be", i), ifa.out_be,
          !tbl[i].x_valid ? 4'h0 : (tbl[i].x_slot ? 4'hC : 4'h3));
      chk($sformatf("v%0d_slot", i), ifa.out_slot, tbl[i].x_slot);
      chk($sformatf("v%0d_start", i), ifa.out_start, tbl[i].x_start);
      chk($sformatf("v%0d_end", i), ifa.out_end, tbl[i].x_end);
      chk($sformatf("v%0d_cnt", i), ifa.fifo_count, tbl[i].x_cnt);
      chk($sformatf("v%0d_burst", i), ifa.burst_active, tbl[i].x_burst);
      chk($sformatf("v%0d_err", i), ifa.protocol_err, tbl[i].x_err);
    end
    ifa.flush = 1'b0; ifa.slot_valid = '0; ifa.slot_start = '0; ifa.slot_end = '0;

    // Backpressure: 6-beat burst into a 4-deep FIFO with the sink stalled
    ifa.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      drive_a0(idx, 5);
      #1;
      got_rdy = ifa.slot_ready[0];
      chk($sformatf("bp_rdy%0d", c), got_rdy, (c < 4) ? 1 : 0);
      @(posedge clk); #1;
      if (got_rdy) idx++;
    end
    chk("bp_cnt_full", ifa.fifo_count, 4);
    chk("bp_burst", ifa.burst_active, 1);
    chk("bp_head_hold", ifa.out_data, 32'h30);
    for (int k = 0; k < 6; k++) begin
      rx_data[k] = '1; rx_st[k] = 1'b0; rx_en[k] = 1'b0;
    end
    ifa.out_ready = 1'b1;
    nrx = 0;
    for (int c = 0; c < 30 && nrx < 6; c++) begin
      if (idx < 6) drive_a0(idx, 5);
      else ifa.slot_valid = '0;
      #1;
      got_rdy = ifa.slot_ready[0] & ifa.slot_valid[0];
      if (ifa.out_valid) begin
        rx_data[nrx] = ifa.out_data; rx_st[nrx] = ifa.out_start; rx_en[nrx] = ifa.out_end;
        nrx++;
      end
      @(posedge clk); #1;
      if (got_rdy) idx++;
    end
    ifa.slot_valid = '0;
    chk("bp_nrx", nrx, 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("bp_data%0d", k), rx_data[k], 32'h30 + 32'(k));
      chk($sformatf("bp_start%0d", k), rx_st[k], (k == 0) ? 1 : 0);
      chk($sformatf("bp_end%0d", k), rx_en[k], (k == 5) ? 1 : 0);
    end
    @(posedge clk); #1;
    chk("bp_drained", ifa.fifo_count, 0);
    chk("bp_unlocked", ifa.burst_active, 0);

    // Round-robin single-beat bursts on instance B
    ifb.slot_valid = 4'hF; ifb.slot_start = 4'hF; ifb.slot_end = 4'hF; ifb.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("rr%0d_rdy", c), ifb.slot_ready, 4'b0001 << (c % 4));
      @(posedge clk); #1;
      chk($sformatf("rr%0d_slot", c), ifb.out_slot, c % 4);
      chk($sformatf("rr%0d_data", c), ifb.out_data, 16'h100 + 16'(c % 4));
      chk($sformatf("rr%0d_flags", c), {ifb.out_start, ifb.out_end}, 2'b11);
      chk($sformatf("rr%0d_cnt", c), ifb.fifo_count, 1);
    end
    ifb.slot_valid = '0;

    // Asynchronous reset in the middle of a burst on instance A
    ifa.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_a0(c, 9);
      @(posedge clk); #1;
    end
    ifa.slot_valid = '0;
    chk("mr_cnt3", ifa.fifo_count, 3);
    chk("mr_burst", ifa.burst_active, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_valid", ifa.out_valid, 0);
    chk("mr_cnt", ifa.fifo_count, 0);
    chk("mr_burst0", ifa.burst_active, 0);
    chk("mr_data", ifa.out_data, 0);
    #2;
    rst = 1'b0;
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mr_post_valid", ifa.out_valid, 0);
    chk("mr_post_cnt", ifa.fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
